// File: rtl/instr_mem_fetch.sv
// Instruction memory for the fetch stage: registered read with valid/ready handshakes,
// a program-load write port, and range-fault reporting. Reset-time clear walk: INSTR_MEM_BOOT_CLEAR_EN.
module instr_mem_fetch #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 100,
    parameter int unsigned       ADDR_W    = 32,
    parameter bit                BYTE_ADDR = 1'b0,
    parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_fault,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              busy
);

    localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d;

    logic              run;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_wr_idx;

    logic [ADDR_W-1:0] rd_idx, pg_idx;
    logic              rd_in_range, pg_in_range, accept;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_data;

    // Range check uses the full-width index so large addresses never alias into the array.
    function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
        return BYTE_ADDR ? (addr >> 2) : addr;
    endfunction

`ifdef INSTR_MEM_BOOT_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
            else                                clr_idx_d = clr_idx_q + IDX_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign run        = (state_q == ST_RUN);
    assign busy       = (state_q == ST_CLEAR);
    assign clr_we     = (state_q == ST_CLEAR);
    assign clr_wr_idx = clr_idx_q;
`else
    assign run        = 1'b1;
    assign busy       = 1'b0;
    assign clr_we     = 1'b0;
    assign clr_wr_idx = '0;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        rd_idx      = word_index(req_addr);
        pg_idx      = word_index(prog_addr);
        rd_in_range = (rd_idx < DEPTH_A);
        pg_in_range = (pg_idx < DEPTH_A);

        req_ready   = run && !prog_we && (!rsp_valid_q || rsp_ready);
        accept      = req_valid && req_ready;

        rsp_valid_d = rsp_valid_q;
        rsp_fault_d = rsp_fault_q;
        rsp_instr_d = rsp_instr_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = !rd_in_range;
            rsp_instr_d = rd_in_range ? mem_q[rd_idx[IDX_W-1:0]] : NOP_WORD;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        wr_en   = 1'b0;
        wr_idx  = clr_wr_idx;
        wr_data = NOP_WORD;
        if (!rst) begin
            if (clr_we) begin
                wr_en = 1'b1;
            end else if (run && prog_we && pg_in_range) begin
                wr_en   = 1'b1;
                wr_idx  = pg_idx[IDX_W-1:0];
                wr_data = prog_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_instr_q <= NOP_WORD;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_instr_q <= rsp_instr_d;
        end
    end

    // NOTE: the storage array has no reset so it maps onto RAM; only the clear walk initialises it.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_fault = rsp_fault_q;
    assign rsp_instr = rsp_instr_q;

endmodule

// File: doc/instr_mem_fetch.md
# instr_mem_fetch

Parametrised, synchronous instruction memory for the CAL-F96 core fetch stage, successor to the flat combinational instruction store. Adds configurable width and depth, word or byte addressing, a registered read path with valid/ready handshakes, a write port for run-time program loading, out-of-range fault reporting, and an optional reset-time clear sequence. Sits between the PC/fetch logic and the decode stage.

## Interface
- `DATA_W`, 32, instruction word width in bits
- `DEPTH`, 100, number of instruction words
- `ADDR_W`, 32, width of request and program addresses
- `BYTE_ADDR`, 0, 0 means the address is a word index; 1 means the address is a byte address, `addr[1:0]` is ignored and index = `addr >> 2`
- `NOP_WORD`, 32'h0, value returned on faults and written by the clear sequence
- `clk` input 1 system clock; all logic on the rising edge
- `rst` input 1 reset, synchronous, active-high
- `req_valid` input 1 fetch request present
- `req_ready` output 1 request accepted this cycle when high together with `req_valid`
- `req_addr` input ADDR_W fetch address
- `rsp_valid` output 1 response word present
- `rsp_ready` input 1 consumer takes the response
- `rsp_instr` output DATA_W fetched instruction
- `rsp_fault` output 1 fetched index was ≥ DEPTH
- `prog_we` input 1 program-load write strobe
- `prog_addr` input ADDR_W write address, decoded the same way as `req_addr`
- `prog_data` input DATA_W write data
- `busy` output 1 clear sequence in progress; no fetches accepted

## Operation
- State machine with two states:
  - CLEAR: counter `clr_idx` walks 0..DEPTH-1, writing NOP_WORD to one word per cycle. Moves to RUN after the write of index DEPTH-1.
  - RUN: normal operation.
- Index: `idx = BYTE_ADDR ? addr >> 2 : addr`. Any `idx` ≥ DEPTH is out of range.
- Fetch: a request is accepted when `req_valid && req_ready`. On the next edge:
  - `rsp_valid` becomes 1.
  - `rsp_instr` becomes `mem[idx]`, or NOP_WORD if out of range.
  - `rsp_fault` becomes 1 if out of range, otherwise 0.
- `req_ready = (state==RUN) && !prog_we && (!rsp_valid || rsp_ready)`.
  - Allows one request per cycle at full throughput.
  - The response register holds steady while `rsp_valid && !rsp_ready`.
- `rsp_valid` clears on a cycle with `rsp_ready` and no new accept.
- Program write:
  - In RUN, `prog_we` writes `prog_data` to `mem[idx]` at the edge.
  - An out-of-range write is dropped silently.
  - In CLEAR, `prog_we` is ignored.
- Same-cycle write and fetch cannot both happen, because `prog_we` forces `req_ready=0`. A write therefore never races a read.
- A write to the address of a word already held in the response register does not change `rsp_instr`.

## Timing
- Reset values, registered on the first edge with `rst=1`:
  - `rsp_valid=0`, `rsp_fault=0`, `rsp_instr=NOP_WORD`.
  - `state=CLEAR` with `clr_idx=0` when the macro is enabled, otherwise `state=RUN`.
- `busy = (state==CLEAR)`. It is combinational from state, so it is 1 during reset when the clear sequence is enabled.
- Read latency: exactly 1 cycle from accept to `rsp_valid`.
- Clear duration: DEPTH cycles after `rst` falls; `busy` is low in cycle DEPTH+1.
- Reset asserted mid-operation:
  - Drops any pending response with no handshake.
  - Restarts the clear at index 0.
  - Memory words not yet cleared keep their old contents until the walk reaches them.
- Index arithmetic uses the full ADDR_W bits; nothing is truncated before the range check. With DEPTH=100, address 0x1_0000_0000 cannot occur at ADDR_W=32, and a large address such as 0xFFFF_FFFF faults.

## Configuration
- `INSTR_MEM_BOOT_CLEAR_EN` defined:
  - Reset enters CLEAR and the DEPTH-cycle walk writes NOP_WORD into every word.
- Not defined:
  - Reset goes straight to RUN; `busy` is tied to 0.
  - Memory contents are unaffected by reset and undefined until programmed.
  - The `clr_idx` counter is not synthesised.

## Test plan
- Clear (macro on, DEPTH=100): pulse `rst` for 1 cycle → `busy` stays high for 100 cycles, then fetch idx 0 and idx 99 → `rsp_instr`=0, `rsp_fault`=0.
- Program then fetch (BYTE_ADDR=0):
  - Write 0x8021_0010 to idx 0 and 0x0043_1000 to idx 1.
  - Fetch 0 and 1 on back-to-back cycles with `rsp_ready=1` → responses in consecutive cycles, in order, no bubbles.
- Backpressure:
  - Fetch idx 1, then hold `rsp_ready=0` for 5 cycles → `rsp_instr` stable at 0x0043_1000 and `req_ready=0`.
  - Raise `rsp_ready` → `req_ready=1` in the same cycle.
- Byte address and fault (BYTE_ADDR=1):
  - Fetch 0x0000_0007 → returns word 1.
  - Fetch 0x0000_0190 (idx 100) → `rsp_fault=1`, `rsp_instr=NOP_WORD`.
  - Write to 0x190 → memory unchanged.
- Write priority: assert `prog_we` and `req_valid` in the same cycle → `req_ready=0` and the write lands; the fetch is accepted the next cycle and returns the new data.
- Reset mid-operation: `rst` asserted while `rsp_valid=1` and `rsp_ready=0` → `rsp_valid=0` the next cycle, `busy=1`, and the clear restarts at index 0.
